sirena_detector: RTL and testbench



---
 rtl/sirena_pkg.sv | 20 ++
 rtl/sirena_edge_sync.sv | 84 ++++++++
 rtl/sirena_detector.sv | 127 ++++++++++++
 tb/tb_sirena_detector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sirena_pkg.sv
// Shared encodings for the siren pitch detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sirena_pkg;

    // Detector tracking state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    // Pitch trend reported on the sweep output; 2'b11 is never produced
    typedef enum logic [1:0] {
        SW_STEADY = 2'b00,
        SW_UP     = 2'b01,
        SW_DOWN   = 2'b10
    } sweep_t;

endpackage

// File: rtl/sirena_edge_sync.sv
// Synchronizes audio_in, optionally deglitches it (SIRENA_DET_GLITCH_EN), emits a one-cycle rise pulse.
// Latency: input setup before edge k -> rise high after edge k+2 (plus GLITCH_N with the filter).
// Backpressure: none; free-running level input, pulse output.
module sirena_edge_sync #(
    parameter int GLITCH_N = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic audio_in,
    output logic rise
);

`ifdef SIRENA_DET_GLITCH_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic lvl;

    // Two-flop synchronizer, previous-level register and registered edge pulse
    always_comb begin
        sync1_d = audio_in;
        sync2_d = sync1_q;
        prev_d  = lvl;
        rise_d  = lvl & ~prev_q;
    end

    // Synchronizer/edge state; everything cleared so the first post-reset edge counts from 0
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    if (FILT_EN && (GLITCH_N > 0)) begin : g_filt
        localparam int GW = $clog2(GLITCH_N + 1);
        logic          filt_q, filt_d;
        logic [GW-1:0] gcnt_q, gcnt_d;

        // Accept a new level only after it has differed for GLITCH_N consecutive cycles
        always_comb begin
            filt_d = filt_q;
            gcnt_d = '0;
            if (sync2_q != filt_q) begin
                if (gcnt_q == GW'(GLITCH_N - 1)) begin
                    filt_d = sync2_q;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
        end

        // Filter level and run-length counter
        always_ff @(posedge clk_in) begin
            if (rst) begin
                filt_q <= 1'b0;
                gcnt_q <= '0;
            end else begin
                filt_q <= filt_d;
                gcnt_q <= gcnt_d;
            end
        end

        assign lvl = filt_q;
    end else begin : g_nofilt
        assign lvl = sync2_q;
    end

    assign rise = rise_q;

endmodule

// File: rtl/sirena_detector.sv
// Measures square-wave period on audio_in and reports tone presence and pitch trend (glitch filter: SIRENA_DET_GLITCH_EN).
// Latency: audio_in rise set up before edge k -> period/period_valid/sweep update at edge k+3.
// Backpressure: none; period_valid is a one-cycle pulse with no ready.
module sirena_detector #(
    parameter int CNT_W    = 18,
    parameter int TIMEOUT  = 2**18 - 1,
    parameter int TOL      = 64,
    parameter int GLITCH_N = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             audio_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             tone_present,
    output logic [1:0]       sweep
);
    import sirena_pkg::*;

    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOL_X = (CNT_W + 1)'(TOL);

    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    sweep_t           sweep_q, sweep_d;
    logic [CNT_W:0]   cnt_x, per_x;
    sweep_t           trend;

    sirena_edge_sync #(
        .GLITCH_N (GLITCH_N)
    ) u_edge (
        .clk_in   (clk_in),
        .rst      (rst),
        .audio_in (audio_in),
        .rise     (rise)
    );

    // Cycle counter: restarts at 1 on each edge, saturates at the timeout value
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != TMO) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Trend of the new period against the last one, one bit wider so the tolerance cannot wrap
    always_comb begin
        cnt_x = {1'b0, cnt_q};
        per_x = {1'b0, period_q};
        trend = SW_STEADY;
        if (cnt_x + TOL_X < per_x) begin
            trend = SW_UP;
        end else if (cnt_x > per_x + TOL_X) begin
            trend = SW_DOWN;
        end
    end

    // Next state and outputs; an edge coinciding with the timeout is a normal capture
    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        sweep_d        = sweep_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (rise) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    state_d        = ST_TRACK;
                end else if (cnt_q == TMO) begin
                    state_d  = ST_IDLE;
                    period_d = '0;
                    sweep_d  = SW_STEADY;
                end
            end
            ST_TRACK: begin
                if (rise) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    sweep_d        = trend;
                end else if (cnt_q == TMO) begin
                    state_d  = ST_IDLE;
                    period_d = '0;
                    sweep_d  = SW_STEADY;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                period_d = '0;
                sweep_d  = SW_STEADY;
            end
        endcase
    end

    // Counter, FSM and output registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q          <= '0;
            state_q        <= ST_IDLE;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            sweep_q        <= SW_STEADY;
        end else begin
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            sweep_q        <= sweep_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign tone_present = (state_q == ST_TRACK);
    assign sweep        = sweep_q;

endmodule

// File: tb/tb_sirena_detector.sv
// Randomized plus directed bench for sirena_detector against an edge-gap reference model.
// Latency: outputs expected 4 cycles after the driven rise (plus GLITCH_N with the filter).
// Backpressure: none.
module tb_sirena_detector;

    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 200;
    localparam int TOL      = 2;
    localparam int GLITCH_N = 3;
`ifdef SIRENA_DET_GLITCH_EN
    localparam int GLITCH_EN = 1;
`else
    localparam int GLITCH_EN = 0;
`endif
    localparam int LAT  = 4 + (GLITCH_EN != 0 ? GLITCH_N : 0);
    localparam int MAXC = 12000;

    logic             clk_in   = 1'b0;
    logic             rst      = 1'b1;
    logic             audio_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             tone_present;
    logic [1:0]       sweep;

    sirena_detector #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .TOL      (TOL),
        .GLITCH_N (GLITCH_N)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .audio_in     (audio_in),
        .period       (period),
        .period_valid (period_valid),
        .tone_present (tone_present),
        .sweep        (sweep)
    );

    always #5 clk_in = ~clk_in;

    // Stimulus plan: runs of (level, length); level 2 = one reset cycle with audio low
    int run_lvl[$];
    int run_len[$];
    int plan_len = 0;

    // Per-cycle stimulus and expectations, indexed by cycle number (1 = first cycle)
    bit aud[MAXC];
    bit rst_a[MAXC];
    bit mlvl[MAXC];
    bit exp_pv[MAXC];
    bit exp_tone[MAXC];
    int exp_per[MAXC];
    int exp_sw[MAXC];
    int ncyc = 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic add_run(input int lvl, input int len);
        run_lvl.push_back(lvl);
        run_len.push_back(len);
        plan_len += len;
    endtask

    task automatic add_per(input int p, input int h);
        add_run(1, h);
        add_run(0, p - h);
    endtask

    task automatic build_plan();
        int sp[6];
        int p;
        sp = '{60, 50, 40, 40, 50, 60};
        add_run(0, 10);
        repeat (8) add_per(40, 20);
        foreach (sp[i]) add_per(sp[i], sp[i] / 2);
        add_run(1, 20);
        add_run(0, 280);
        add_per(200, 10);
        add_per(200, 10);
        add_per(201, 10);
        repeat (4) add_per(40, 20);
        add_run(1, 20);
        add_run(0, 10);
        add_run(2, 1);
        add_run(0, 10);
        repeat (4) add_per(40, 20);
        repeat (6) begin
            add_run(1, 20);
            add_run(0, 8);
            add_run(1, 2);
            add_run(0, 10);
        end
        p = 40;
        for (int i = 0; i < 70 && plan_len < MAXC - 800; i++) begin
            case ($urandom_range(0, 7))
                0:       p = int'($urandom_range(195, 205));
                1, 2, 3: p = p + int'($urandom_range(0, 2 * TOL + 2)) - (TOL + 1);
                default: p = int'($urandom_range(6, 120));
            endcase
            if (p < 6)   p = 6;
            if (p > 205) p = 205;
            add_per(p, int'($urandom_range(3, p - 3)));
        end
        add_run(1, 10);
        add_run(0, TIMEOUT + LAT + 20);
    endtask

    // Expand runs into per-cycle drive values; the model level drops pulses the filter would reject
    task automatic expand();
        int c;
        c = 1;
        foreach (run_lvl[i]) begin
            for (int k = 0; k < run_len[i]; k++) begin
                aud[c]   = (run_lvl[i] == 1);
                rst_a[c] = (run_lvl[i] == 2);
                mlvl[c]  = (run_lvl[i] == 1) && !(GLITCH_EN != 0 && run_len[i] < GLITCH_N);
                c++;
            end
        end
        ncyc = c;
    endtask

    task automatic fill(input int from, input bit tone, input int per, input int sw);
        for (int c = from; c < ncyc; c++) begin
            exp_tone[c] = tone;
            exp_per[c]  = per;
            exp_sw[c]   = sw;
        end
    endtask

    // Reference: work from gaps between rising edges of the driven waveform
    task automatic build_model();
        int edges_seen;
        int last;
        int per;
        int sw;
        int g;
        edges_seen = 0;
        last = 0;
        per = 0;
        sw = 0;
        fill(1, 1'b0, 0, 0);
        for (int n = 1; n < ncyc; n++) begin
            if (rst_a[n]) begin
                fill(n + 1, 1'b0, 0, 0);
                edges_seen = 0;
                per = 0;
                sw = 0;
            end else if (mlvl[n] && !mlvl[n-1]) begin
                if (edges_seen > 0) begin
                    g = n - last;
                    if (edges_seen > 1) begin
                        if (g + TOL < per)      sw = 1;
                        else if (g > per + TOL) sw = 2;
                        else                    sw = 0;
                    end
                    per = g;
                    if (n + LAT < ncyc) exp_pv[n + LAT] = 1'b1;
                    fill(n + LAT, 1'b1, per, sw);
                end
                edges_seen++;
                last = n;
            end else if (edges_seen > 0 && n - last == TIMEOUT) begin
                fill(n + LAT, 1'b0, 0, 0);
                edges_seen = 0;
                per = 0;
                sw = 0;
            end
        end
    endtask

    initial begin
        build_plan();
        expand();
        build_model();
        rst = 1'b1;
        audio_in = 1'b0;
        repeat (3) @(posedge clk_in);
        for (int n = 1; n < ncyc; n++) begin
            @(posedge clk_in);
            #1;
            audio_in = aud[n];
            rst      = rst_a[n];
            @(negedge clk_in);
            chk($sformatf("period_valid@%0d", n), int'(period_valid), int'(exp_pv[n]));
            chk($sformatf("tone_present@%0d", n), int'(tone_present), int'(exp_tone[n]));
            chk($sformatf("period@%0d", n), int'(period), exp_per[n]);
            chk($sformatf("sweep@%0d", n), int'(sweep), exp_sw[n]);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
